clk_div_checker: RTL and testbench

Self-checking period/duty monitor that sits directly downstream of the clock divider stage. It samples one divided clock or strobe (`clk_div_2` … `clk_div_28`, `clk_div_5`) in the `clk_in` domain and measures `NUM_PER` consecutive periods. It compares each measurement against an expected period and high time and reports pass/fail flags with a one-cycle `done` pulse. It is used on-board and in simulation to confirm the divider outputs without a logic analyser.

---
 rtl/clk_div_checker_if.sv | 26 ++
 rtl/clk_div_checker.sv | 154 +++++++++++++++
 tb/tb_clk_div_checker.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_checker_if.sv
// Handshake and result bundle between a divider-output checker and its controller.
interface clk_div_checker_if #(
    parameter int CNT_W = 8
);
    logic             sig_in;
    logic             start;
    logic [CNT_W-1:0] exp_period;
    logic [CNT_W-1:0] exp_high;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_err;
    logic             duty_err;
    logic             timeout;

    modport master (
        output sig_in, start, exp_period, exp_high,
        input  busy, done, period_out, high_out, period_err, duty_err, timeout
    );

    modport slave (
        input  sig_in, start, exp_period, exp_high,
        output busy, done, period_out, high_out, period_err, duty_err, timeout
    );
endinterface

// File: rtl/clk_div_checker.sv
// Period/duty monitor for one divided clock sampled in the clk_in domain.
// Define CLK_DIV_CHECKER_DUTY_CHECK_EN to enable high-time measurement and duty_err.
module clk_div_checker #(
    parameter int CNT_W   = 8,
    parameter int NUM_PER = 4,
    parameter int TOL     = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    clk_div_checker_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
    typedef enum logic [2:0] {IDLE, ARM, HIGH, LOW, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, ARM, COUNT, FIN} state_t;
`endif

    state_t           state;
    logic             s_q;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       idx;
    logic [CNT_W-1:0] exp_period_q;
    logic [CNT_W-1:0] period_q;
    logic             perr_q;
    logic             tout_q;
    logic             busy_q;
    logic             done_q;
    logic             rise;

    assign rise = bus.sig_in & ~s_q;

`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
    logic [CNT_W-1:0] exp_high_q;
    logic [CNT_W-1:0] high_q;
    logic             derr_q;
    logic             fall;
    assign fall = ~bus.sig_in & s_q;
`else
    logic unused_exp_high;
    assign unused_exp_high = ^bus.exp_high;
`endif

    // Widened by one bit so the difference never wraps.
    function automatic logic off_tol(input logic [CNT_W-1:0] meas, input logic [CNT_W-1:0] expv);
        logic [CNT_W:0] a;
        logic [CNT_W:0] b;
        logic [CNT_W:0] d;
        a = {1'b0, meas};
        b = {1'b0, expv};
        d = (a >= b) ? a - b : b - a;
        return d > (CNT_W+1)'(TOL);
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state        <= IDLE;
            s_q          <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            exp_period_q <= '0;
            period_q     <= '0;
            perr_q       <= 1'b0;
            tout_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
            exp_high_q   <= '0;
            high_q       <= '0;
            derr_q       <= 1'b0;
`endif
        end else begin
            s_q    <= bus.sig_in;
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    exp_period_q <= bus.exp_period;
                    period_q     <= '0;
                    perr_q       <= 1'b0;
                    tout_q       <= 1'b0;
                    idx          <= '0;
                    cnt          <= '0;
                    busy_q       <= 1'b1;
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
                    exp_high_q   <= bus.exp_high;
                    high_q       <= '0;
                    derr_q       <= 1'b0;
`endif
                    state        <= ARM;
                end
                FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    // Saturation wins over any edge in the same cycle.
                    if (cnt == CNT_MAX) begin
                        tout_q <= 1'b1;
                        perr_q <= 1'b1;
                        state  <= FIN;
                    end else if (state == ARM) begin
                        if (rise) begin
                            cnt   <= 1;
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
                            state <= HIGH;
`else
                            state <= COUNT;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
                    end else if (state == HIGH) begin
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            high_q <= cnt;
                            if (off_tol(cnt, exp_high_q)) derr_q <= 1'b1;
                            state  <= LOW;
                        end
`endif
                    end else if (rise) begin
                        period_q <= cnt;
                        if (off_tol(cnt, exp_period_q)) perr_q <= 1'b1;
                        cnt <= 1;
                        idx <= idx + 1'b1;
                        if (idx == 4'(NUM_PER - 1)) state <= FIN;
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
                        else state <= HIGH;
`else
                        else state <= COUNT;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.period_out = period_q;
    assign bus.period_err = perr_q;
    assign bus.timeout    = tout_q;
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
    assign bus.high_out   = high_q;
    assign bus.duty_err   = derr_q;
`else
    assign bus.high_out   = '0;
    assign bus.duty_err   = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker: a TOL=1 instance and a TOL=0 instance share one stimulus.
module tb_clk_div_checker;
`ifdef CLK_DIV_CHECKER_DUTY_CHECK_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif
    localparam int LIMIT = 3000;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       sig;
    logic       start;
    logic [7:0] exp_period;
    logic [7:0] exp_high;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc;
    int d0;

    int gen_div = 2;
    int gen_ha = 1;
    int gen_hb = 1;
    bit gen_en = 1'b0;

    clk_div_checker_if #(.CNT_W(8)) bus  ();
    clk_div_checker_if #(.CNT_W(8)) bus0 ();

    assign bus.sig_in      = sig;
    assign bus.start       = start;
    assign bus.exp_period  = exp_period;
    assign bus.exp_high    = exp_high;
    assign bus0.sig_in     = sig;
    assign bus0.start      = start;
    assign bus0.exp_period = exp_period;
    assign bus0.exp_high   = exp_high;

    clk_div_checker #(.CNT_W(8), .NUM_PER(4), .TOL(1)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    clk_div_checker #(.CNT_W(8), .NUM_PER(4), .TOL(0)) dut_t0 (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus0)
    );

    always #5 clk_in = ~clk_in;

    // Divider model: high for gen_ha / gen_hb cycles on alternating periods.
    initial begin
        int ph;
        bit alt;
        int hi;
        ph  = 0;
        alt = 1'b0;
        sig = 1'b0;
        forever begin
            @(negedge clk_in);
            if (!gen_en) begin
                sig = 1'b0;
                ph  = 0;
                alt = 1'b0;
            end else begin
                hi  = alt ? gen_hb : gen_ha;
                sig = (ph < hi);
                if (ph == gen_div - 1) begin
                    ph  = 0;
                    alt = !alt;
                end else begin
                    ph++;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk_in);
        if (bus.done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic setup_gen(input int div, input int ha, input int hb, input bit en);
        gen_en = 1'b0;
        repeat (3) @(negedge clk_in);
        gen_div = div;
        gen_ha  = ha;
        gen_hb  = hb;
        gen_en  = en;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic kick(input int ep, input int eh);
        exp_period = 8'(ep);
        exp_high   = 8'(eh);
        start      = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        chk("busy_rise", {31'd0, bus.busy}, 1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!bus.done && cycles < LIMIT) begin
            @(negedge clk_in);
            cycles++;
        end
        chk("done_seen", {31'd0, bus.done}, 1);
        chk("busy_fall", {31'd0, bus.busy}, 0);
    endtask

    task automatic chk_res(input string tag, input int per, input int hi,
                           input bit perr, input bit derr, input bit tout);
        chk({tag, "_period"}, {24'd0, bus.period_out}, per);
        chk({tag, "_high"}, {24'd0, bus.high_out}, DUTY ? hi : 0);
        chk({tag, "_perr"}, {31'd0, bus.period_err}, {31'd0, perr});
        chk({tag, "_derr"}, {31'd0, bus.duty_err}, {31'd0, derr & DUTY});
        chk({tag, "_tout"}, {31'd0, bus.timeout}, {31'd0, tout});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 0);
        chk({tag, "_done"}, {31'd0, bus.done}, 0);
        chk_res(tag, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        exp_period = '0;
        exp_high   = '0;
        repeat (3) @(negedge clk_in);
        chk_zero("reset");
        rst = 1'b0;

        // clk_div_2
        setup_gen(2, 1, 1, 1'b1);
        kick(2, 1);
        wait_done(cyc);
        chk_res("div2", 2, 1, 1'b0, 1'b0, 1'b0);

        // clk_div_28 and tolerance edges on both period and high time
        setup_gen(28, 14, 14, 1'b1);
        kick(28, 14);
        wait_done(cyc);
        chk_res("div28", 28, 14, 1'b0, 1'b0, 1'b0);
        kick(30, 14);
        wait_done(cyc);
        chk_res("div28_p30", 28, 14, 1'b1, 1'b0, 1'b0);
        kick(29, 15);
        wait_done(cyc);
        chk_res("div28_p29", 28, 14, 1'b0, 1'b0, 1'b0);
        chk("div28_p29_t0_perr", {31'd0, bus0.period_err}, 1);
        kick(27, 16);
        wait_done(cyc);
        chk_res("div28_h16", 28, 14, 1'b0, 1'b1, 1'b0);

        // clk_div_5: sampled high alternates 2/3
        setup_gen(5, 2, 3, 1'b1);
        kick(5, 2);
        wait_done(cyc);
        chk("div5_period", {24'd0, bus.period_out}, 5);
        chk("div5_high_ok", {31'd0, DUTY ? (bus.high_out == 8'd2 || bus.high_out == 8'd3)
                                         : (bus.high_out == 8'd0)}, 1);
        chk("div5_perr", {31'd0, bus.period_err}, 0);
        chk("div5_derr", {31'd0, bus.duty_err}, 0);
        chk("div5_t0_perr", {31'd0, bus0.period_err}, 0);
        chk("div5_t0_derr", {31'd0, bus0.duty_err}, {31'd0, DUTY});

        // sig_in held low: counter saturates
        setup_gen(2, 1, 1, 1'b0);
        kick(2, 1);
        wait_done(cyc);
        chk("tout_cycles", cyc, 257);
        chk_res("tout", 0, 0, 1'b1, 1'b0, 1'b1);

        // Reset mid-run on clk_div_16, then a clean run
        setup_gen(16, 8, 8, 1'b1);
        kick(16, 8);
        repeat (10) @(negedge clk_in);
        d0  = n_done;
        rst = 1'b1;
        @(negedge clk_in);
        chk_zero("midrst");
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("midrst_no_done", n_done, d0);
        kick(16, 8);
        wait_done(cyc);
        chk_res("div16", 16, 8, 1'b0, 1'b0, 1'b0);

        // Second start while busy, with different expectations on the bus
        setup_gen(28, 14, 14, 1'b1);
        d0 = n_done;
        kick(28, 14);
        repeat (20) @(negedge clk_in);
        exp_period = 8'd50;
        exp_high   = 8'd3;
        start      = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        wait_done(cyc);
        chk_res("restart", 28, 14, 1'b0, 1'b0, 1'b0);
        repeat (8) @(negedge clk_in);
        chk("restart_one_done", n_done - d0, 1);
        chk("restart_idle_busy", {31'd0, bus.busy}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
